// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that shares one combinational ALU among NREQ requesters and
// returns results through a one-entry pipelined response register.
// Optional counters (grant_cnt, stall_cnt) are added when ALU_SHARE_ARB_STATS_EN is defined.
module alu_share_arbiter #(
  parameter int NREQ = 2,
  parameter int W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_val,
  output logic [NREQ-1:0]   req_rdy,
  input  logic [4*NREQ-1:0] req_fn,
  input  logic [W*NREQ-1:0] req_in0,
  input  logic [W*NREQ-1:0] req_in1,
  output logic [3:0]        alu_fn,
  output logic [W-1:0]      alu_in0,
  output logic [W-1:0]      alu_in1,
  input  logic [W-1:0]      alu_out,
  input  logic              alu_ops_eq,
  input  logic              alu_ops_lt,
  input  logic              alu_ops_ltu,
  output logic [NREQ-1:0]   resp_val,
  input  logic [NREQ-1:0]   resp_rdy,
  output logic [W-1:0]      resp_data,
  output logic              resp_eq,
  output logic              resp_lt,
  output logic              resp_ltu
`ifdef ALU_SHARE_ARB_STATS_EN
  ,
  output logic [16*NREQ-1:0] grant_cnt,
  output logic [15:0]        stall_cnt
`endif
);

  localparam int IDX_W = $clog2(NREQ);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] ptr_nxt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_any;
  logic             drain;
  logic             can_accept;
  logic             accept;

  logic             full_p1;
  logic [IDX_W-1:0] owner_p1;
  logic [W-1:0]     data_p1;
  logic             eq_p1;
  logic             lt_p1;
  logic             ltu_p1;

  // Stage 0: round-robin pick and ALU operand steering
  always_comb begin
    int idx;
    idx     = 0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_any && req_val[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = IDX_W'(idx);
      end
    end
  end

  assign drain      = full_p1 & resp_rdy[owner_p1];
  assign can_accept = ~full_p1 | drain;
  // Gating with reset keeps grants and ALU operands at zero while reset is held.
  assign accept     = gnt_any & can_accept & reset;
  assign ptr_nxt    = (gnt_idx == IDX_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    req_rdy = '0;
    alu_fn  = '0;
    alu_in0 = '0;
    alu_in1 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (accept && gnt_idx == IDX_W'(i)) begin
        req_rdy[i] = 1'b1;
        alu_fn     = req_fn[4*i +: 4];
        alu_in0    = req_in0[W*i +: W];
        alu_in1    = req_in1[W*i +: W];
      end
    end
  end

  // Stage 1: response register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr      <= '0;
      full_p1  <= 1'b0;
      owner_p1 <= '0;
      data_p1  <= '0;
      eq_p1    <= 1'b0;
      lt_p1    <= 1'b0;
      ltu_p1   <= 1'b0;
    end else if (accept) begin
      ptr      <= ptr_nxt;
      full_p1  <= 1'b1;
      owner_p1 <= gnt_idx;
      data_p1  <= alu_out;
      eq_p1    <= alu_ops_eq;
      lt_p1    <= alu_ops_lt;
      ltu_p1   <= alu_ops_ltu;
    end else if (drain) begin
      full_p1  <= 1'b0;
    end
  end

  always_comb begin
    resp_val = '0;
    if (full_p1) resp_val[owner_p1] = 1'b1;
  end

  assign resp_data = data_p1;
  assign resp_eq   = eq_p1;
  assign resp_lt   = lt_p1;
  assign resp_ltu  = ltu_p1;

`ifdef ALU_SHARE_ARB_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic stall;
  assign stall = full_p1 & ~resp_rdy[owner_p1] & (|req_val);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_rdy[i]) grant_cnt[16*i +: 16] <= sat_inc16(grant_cnt[16*i +: 16]);
      end
      if (stall) stall_cnt <= sat_inc16(stall_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter (NREQ=2, W=32) with a small behavioural ALU
// attached to the shared ALU ports.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_val;
  logic [1:0]  req_rdy;
  logic [7:0]  req_fn;
  logic [63:0] req_in0;
  logic [63:0] req_in1;
  logic [3:0]  alu_fn;
  logic [31:0] alu_in0;
  logic [31:0] alu_in1;
  logic [31:0] alu_out;
  logic        alu_ops_eq;
  logic        alu_ops_lt;
  logic        alu_ops_ltu;
  logic [1:0]  resp_val;
  logic [1:0]  resp_rdy;
  logic [31:0] resp_data;
  logic        resp_eq;
  logic        resp_lt;
  logic        resp_ltu;
`ifdef ALU_SHARE_ARB_STATS_EN
  logic [31:0] grant_cnt;
  logic [15:0] stall_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.NREQ(2), .W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_val     (req_val),
    .req_rdy     (req_rdy),
    .req_fn      (req_fn),
    .req_in0     (req_in0),
    .req_in1     (req_in1),
    .alu_fn      (alu_fn),
    .alu_in0     (alu_in0),
    .alu_in1     (alu_in1),
    .alu_out     (alu_out),
    .alu_ops_eq  (alu_ops_eq),
    .alu_ops_lt  (alu_ops_lt),
    .alu_ops_ltu (alu_ops_ltu),
    .resp_val    (resp_val),
    .resp_rdy    (resp_rdy),
    .resp_data   (resp_data),
    .resp_eq     (resp_eq),
    .resp_lt     (resp_lt),
    .resp_ltu    (resp_ltu)
`ifdef ALU_SHARE_ARB_STATS_EN
    ,
    .grant_cnt   (grant_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  // Shared ALU: 0 ADD, 1 SUB, 6 SLT, 7 SLTU
  always_comb begin
    alu_ops_eq  = (alu_in0 == alu_in1);
    alu_ops_lt  = ($signed(alu_in0) < $signed(alu_in1));
    alu_ops_ltu = (alu_in0 < alu_in1);
    case (alu_fn)
      4'd0:    alu_out = alu_in0 + alu_in1;
      4'd1:    alu_out = alu_in0 - alu_in1;
      4'd6:    alu_out = {31'd0, alu_ops_lt};
      4'd7:    alu_out = {31'd0, alu_ops_ltu};
      default: alu_out = 32'd0;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b0;
    req_val  = 2'b11;
    resp_rdy = 2'b00;
    req_fn   = 8'h00;
    req_in0  = {32'd9, 32'd5};
    req_in1  = {32'd4, 32'd7};
    tick();
    tick();
    chk("rst_req_rdy", 64'(req_rdy), 64'd0);
    chk("rst_resp_val", 64'(resp_val), 64'd0);
    chk("rst_alu_in0", 64'(alu_in0), 64'd0);
    chk("rst_alu_in1", 64'(alu_in1), 64'd0);
    chk("rst_resp_data", 64'(resp_data), 64'd0);
`ifdef ALU_SHARE_ARB_STATS_EN
    chk("rst_grant_cnt", 64'(grant_cnt), 64'd0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    reset   = 1'b1;
    req_val = 2'b00;
    tick();

    // Single request: 5 + 7
    req_val  = 2'b01;
    resp_rdy = 2'b11;
    #1;
    chk("single_req_rdy", 64'(req_rdy), 64'd1);
    chk("single_alu_in0", 64'(alu_in0), 64'd5);
    chk("single_alu_in1", 64'(alu_in1), 64'd7);
    tick();
    req_val = 2'b00;
    #1;
    chk("single_resp_val", 64'(resp_val), 64'd1);
    chk("single_resp_data", 64'(resp_data), 64'd12);
    chk("single_idle_rdy", 64'(req_rdy), 64'd0);
    tick();
    chk("single_drained", 64'(resp_val), 64'd0);

    // Backpressure on requester 1: 3 - 5
    req_val        = 2'b10;
    req_fn[7:4]    = 4'd1;
    req_in0[63:32] = 32'd3;
    req_in1[63:32] = 32'd5;
    resp_rdy       = 2'b00;
    #1;
    chk("bp_grant1", 64'(req_rdy), 64'd2);
    chk("bp_alu_fn", 64'(alu_fn), 64'd1);
    tick();
    req_val = 2'b11;
    req_fn  = 8'h00;
    req_in0 = {32'd10, 32'd1};
    req_in1 = {32'd20, 32'd2};
    for (int c = 0; c < 3; c++) begin
      resp_rdy = (c == 1) ? 2'b01 : 2'b00;
      #1;
      chk("bp_resp_val", 64'(resp_val), 64'd2);
      chk("bp_resp_data", 64'(resp_data), 64'hFFFF_FFFE);
      chk("bp_req_rdy", 64'(req_rdy), 64'd0);
      tick();
    end
    resp_rdy = 2'b10;
    #1;
`ifdef ALU_SHARE_ARB_STATS_EN
    chk("stall_cnt", 64'(stall_cnt), 64'd3);
`endif
    chk("drain_resp_val", 64'(resp_val), 64'd2);
    chk("drain_new_grant", 64'(req_rdy), 64'd1);
    chk("drain_alu_in0", 64'(alu_in0), 64'd1);
    tick();

    // Contention: grants alternate, one response per cycle
    resp_rdy = 2'b11;
    #1;
    chk("rr0_resp_val", 64'(resp_val), 64'd1);
    chk("rr0_resp_data", 64'(resp_data), 64'd3);
    chk("rr0_req_rdy", 64'(req_rdy), 64'd2);
    tick();
    chk("rr1_resp_val", 64'(resp_val), 64'd2);
    chk("rr1_resp_data", 64'(resp_data), 64'd30);
    chk("rr1_req_rdy", 64'(req_rdy), 64'd1);
    tick();
    chk("rr2_resp_val", 64'(resp_val), 64'd1);
    chk("rr2_resp_data", 64'(resp_data), 64'd3);
    chk("rr2_req_rdy", 64'(req_rdy), 64'd2);
    tick();
    req_val = 2'b00;
    #1;
    chk("rr3_resp_val", 64'(resp_val), 64'd2);
    chk("rr3_resp_data", 64'(resp_data), 64'd30);
`ifdef ALU_SHARE_ARB_STATS_EN
    chk("grant_cnt", 64'(grant_cnt), {32'd0, 16'd3, 16'd3});
    chk("stall_cnt_hold", 64'(stall_cnt), 64'd3);
`endif
    tick();
    chk("rr_drained", 64'(resp_val), 64'd0);

    // Flags: SLT of -1 and 1
    req_val       = 2'b01;
    req_fn[3:0]   = 4'd6;
    req_in0[31:0] = 32'hFFFF_FFFF;
    req_in1[31:0] = 32'd1;
    #1;
    chk("flag_grant", 64'(req_rdy), 64'd1);
    tick();
    req_val = 2'b00;
    #1;
    chk("flag_data", 64'(resp_data), 64'd1);
    chk("flag_lt", 64'(resp_lt), 64'd1);
    chk("flag_ltu", 64'(resp_ltu), 64'd0);
    chk("flag_eq", 64'(resp_eq), 64'd0);
    tick();

    // Reset while a response for requester 1 is held
    req_val        = 2'b10;
    req_fn[7:4]    = 4'd0;
    req_in0[63:32] = 32'd4;
    req_in1[63:32] = 32'd4;
    resp_rdy       = 2'b00;
    #1;
    chk("rf_grant1", 64'(req_rdy), 64'd2);
    tick();
    req_val = 2'b11;
    #1;
    chk("rf_resp_val", 64'(resp_val), 64'd2);
    chk("rf_resp_data", 64'(resp_data), 64'd8);
    chk("rf_resp_eq", 64'(resp_eq), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("rf_cleared_val", 64'(resp_val), 64'd0);
    chk("rf_cleared_data", 64'(resp_data), 64'd0);
    chk("rf_cleared_eq", 64'(resp_eq), 64'd0);
    chk("rf_cleared_rdy", 64'(req_rdy), 64'd0);
`ifdef ALU_SHARE_ARB_STATS_EN
    chk("rf_grant_cnt", 64'(grant_cnt), 64'd0);
    chk("rf_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    tick();
    reset    = 1'b1;
    resp_rdy = 2'b11;
    #1;
    chk("post_rst_grant0", 64'(req_rdy), 64'd1);
    tick();
    chk("post_rst_resp_val", 64'(resp_val), 64'd1);
    chk("post_rst_resp_data", 64'(resp_data), 64'd1);
    chk("post_rst_next_grant", 64'(req_rdy), 64'd2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
